alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the combinational execute ALU.
- Supports 8/16/32-bit operand sizes, plus 64-bit when WIDTH=64, and the same operation set.
- Produces complete x86 flag values alongside the set mask, rather than the mask alone.
- Sits between the operand-fetch and writeback stages, with valid/ready handshakes on both sides and a flush for pipeline squash.

---
 rtl/alu_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined execute ALU (8/16/32/64-bit) producing x86 flag values and write mask.
// Define ALU_PIPE_SUB_EN to build the SUB/CMP subtract path; otherwise opcodes 8/9 decode as illegal.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opsize,
  input  logic [OPW-1:0]   alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [5:0]       set_eflags,
  output logic [5:0]       eflags_out,
  output logic             illegal
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_AND  = OPW'(1);
  localparam logic [OPW-1:0] OP_BSF  = OPW'(2);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4);
  localparam logic [OPW-1:0] OP_PASS = OPW'(5);
  localparam logic [OPW-1:0] OP_SAL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SAR  = OPW'(7);
`ifdef ALU_PIPE_SUB_EN
  localparam logic [OPW-1:0] OP_SUB  = OPW'(8);
  localparam logic [OPW-1:0] OP_CMP  = OPW'(9);
`endif

  function automatic logic [WIDTH-1:0] size_mask(input logic [1:0] sz);
    logic [WIDTH-1:0] m;
    case (sz)
      2'd0:    m = WIDTH'(8'hFF);
      2'd1:    m = WIDTH'(16'hFFFF);
      2'd2:    m = WIDTH'(32'hFFFF_FFFF);
      default: m = '1;
    endcase
    return m;
  endfunction

  logic             s1_valid_q, s2_valid_q;
  logic             in_fire, s2_load;

  logic [WIDTH-1:0] a_q, b_q, logic_q;
  logic [WIDTH:0]   arith_q;
  logic [5:0]       cnt_q;
  logic [OPW-1:0]   op_q;
  logic [1:0]       opsize_q;
  logic             ill1_q;

  logic [WIDTH-1:0] m_in, a_m, b_m, logic_d;
  logic [WIDTH:0]   arith_d;
  logic [5:0]       cnt_d;
  logic             ill1_d;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [5:0]       set_q, set_d, flags_q, flags_d;
  logic             illegal_q, illegal_d;

  assign in_ready = !flush && (!s1_valid_q || !s2_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  // Stage 1: operand masking, adder/subtractor, logic ops, shift count, legality
  always_comb begin
    m_in = size_mask(opsize);
    a_m  = a & m_in;
    b_m  = b & m_in;
`ifdef ALU_PIPE_SUB_EN
    if (alu_op == OP_SUB || alu_op == OP_CMP) arith_d = {1'b0, a_m} - {1'b0, b_m};
    else                                      arith_d = {1'b0, a_m} + {1'b0, b_m};
`else
    arith_d = {1'b0, a_m} + {1'b0, b_m};
`endif
    case (alu_op)
      OP_AND:  logic_d = a_m & b_m;
      OP_OR:   logic_d = a_m | b_m;
      OP_NOT:  logic_d = ~a_m & m_in;
      OP_PASS: logic_d = b_m;
      default: logic_d = '0;
    endcase
    cnt_d  = (opsize == 2'd3) ? b[5:0] : {1'b0, b[4:0]};
    ill1_d = (WIDTH == 32) && (opsize == 2'd3);
    case (alu_op)
      OP_ADD, OP_AND, OP_NOT, OP_OR, OP_PASS, OP_SAL, OP_SAR: ;
      OP_BSF: if (opsize == 2'd0) ill1_d = 1'b1;
`ifdef ALU_PIPE_SUB_EN
      OP_SUB, OP_CMP: ;
`endif
      default: ill1_d = 1'b1;
    endcase
  end

  logic [WIDTH-1:0]        m, sign_m, res, sa_x, bsf_idx;
  logic [WIDTH:0]          sh_l;
  logic signed [WIDTH:0]   sh_r;
  logic [6:0]              sz7;
  logic                    cnt_ge, a_s, b_s, r_s, is_sub;
  logic                    of, zf, af, cf;

  // Stage 2: shifts, bit scan, flag generation and zero-extension
  always_comb begin
    m       = size_mask(opsize_q);
    sign_m  = m ^ (m >> 1);
    sz7     = 7'd8 << opsize_q;
    cnt_ge  = {1'b0, cnt_q} >= sz7;
    a_s     = |(a_q & sign_m);
    b_s     = |(b_q & sign_m);
    r_s     = |(arith_q[WIDTH-1:0] & sign_m);
    sh_l    = {1'b0, a_q} << cnt_q;
    sa_x    = a_q | (a_s ? ~m : '0);
    sh_r    = $signed({sa_x, 1'b0}) >>> cnt_q;
    bsf_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (b_q[i]) bsf_idx = WIDTH'(i);
    end
    is_sub = 1'b0;
`ifdef ALU_PIPE_SUB_EN
    is_sub = (op_q == OP_SUB) || (op_q == OP_CMP);
`endif
    res   = '0;
    set_d = '0;
    of    = 1'b0;
    af    = 1'b0;
    cf    = 1'b0;
    case (op_q)
      OP_AND, OP_OR: begin
        res   = logic_q;
        set_d = 6'b111011;
      end
      OP_NOT, OP_PASS: res = logic_q;
      OP_BSF: begin
        res   = (b_q == '0) ? a_q : bsf_idx;
        set_d = 6'b001000;
      end
      OP_SAL, OP_SAR: begin
        if (cnt_q == 6'd0) begin
          res = a_q;
        end else begin
          // OF is only architecturally defined for single-bit shifts
          set_d = {cnt_q == 6'd1, 5'b11011};
          if (op_q == OP_SAL) begin
            res = sh_l[WIDTH-1:0] & m;
            cf  = !cnt_ge && |(sh_l & {sign_m, 1'b0});
            of  = |(res & sign_m) ^ cf;
          end else begin
            res = sh_r[WIDTH:1] & m;
            cf  = sh_r[0];
          end
        end
      end
      default: begin
        res   = arith_q[WIDTH-1:0] & m;
        set_d = 6'b111111;
        cf    = |(arith_q & {sign_m, 1'b0});
        af    = a_q[4] ^ b_q[4] ^ arith_q[4];
        of    = is_sub ? ((a_s != b_s) && (r_s != a_s)) : ((a_s == b_s) && (r_s != a_s));
      end
    endcase
    zf        = (op_q == OP_BSF) ? (b_q == '0) : (res == '0);
    flags_d   = {of, |(res & sign_m), zf, af, cf, ~^res[7:0]};
    alu_out_d = res;
`ifdef ALU_PIPE_SUB_EN
    if (op_q == OP_CMP) alu_out_d = a_q;
`endif
    illegal_d = ill1_q;
    if (ill1_q) begin
      alu_out_d = '0;
      set_d     = '0;
      flags_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      logic_q    <= '0;
      arith_q    <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      opsize_q   <= '0;
      ill1_q     <= 1'b0;
      alu_out_q  <= '0;
      set_q      <= '0;
      flags_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (in_fire)      s1_valid_q <= 1'b1;
        else if (s2_load) s1_valid_q <= 1'b0;
        if (s2_load)        s2_valid_q <= 1'b1;
        else if (out_ready) s2_valid_q <= 1'b0;
      end
      if (in_fire) begin
        a_q      <= a_m;
        b_q      <= b_m;
        logic_q  <= logic_d;
        arith_q  <= arith_d;
        cnt_q    <= cnt_d;
        op_q     <= alu_op;
        opsize_q <= opsize;
        ill1_q   <= ill1_d;
      end
      if (s2_load && !flush) begin
        alu_out_q <= alu_out_d;
        set_q     <= set_d;
        flags_q   <= flags_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign alu_out    = alu_out_q;
  assign set_eflags = set_q;
  assign eflags_out = flags_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors pushed on issue, checked by a monitor on each output transfer.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] a, b, alu_out;
  logic [1:0]  opsize;
  logic [3:0]  alu_op;
  logic [5:0]  set_eflags, eflags_out;

  typedef struct {
    logic [31:0] out;
    logic [5:0]  mask;
    logic [5:0]  flags;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  alu_pipe #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opsize(opsize), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .set_eflags(set_eflags), .eflags_out(eflags_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  function automatic exp_t mk(input logic [31:0] o, input logic [5:0] mk_, input logic [5:0] f, input logic il);
    exp_t e;
    e.out = o; e.mask = mk_; e.flags = f; e.ill = il;
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [1:0] sz, input logic [31:0] av,
                      input logic [31:0] bv, input exp_t e);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; alu_op = op; opsize = sz; a = av; b = bv;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    else exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 60) begin
      @(negedge clk); t++;
    end
    #3;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Output monitor: pops one expectation per completed output transfer
  logic        hold_pend = 1'b0;
  logic [31:0] hold_out;
  logic [5:0]  hold_set;
  always begin
    @(negedge clk); #2;
    if (!reset_n || flush) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", alu_out, hold_out);
        chk("hold_set", set_eflags, hold_set);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", alu_out, 0);
          n_fail++;
          $display("FAIL unexpected_output: got out_valid=1 expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("alu_out", alu_out, e.out);
          chk("set_eflags", set_eflags, e.mask);
          chk("eflags_out", eflags_out & e.mask, e.flags & e.mask);
          chk("illegal", illegal, e.ill);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_out  = alu_out;
      hold_set  = set_eflags;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; opsize = '0; alu_op = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_set", set_eflags, 0);
    chk("rst_flags", eflags_out, 0);
    chk("rst_illegal", illegal, 0);
    reset_n = 1'b1;

    // latency: not yet valid after the accepting edge, valid after the next one
    send(4'd0, 2'd0, 32'h7F, 32'h01, mk(32'h80, 6'b111111, 6'b110100, 1'b0));
    chk("lat_first_edge", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_second_edge", out_valid, 1);

    send(4'd6, 2'd2, 32'h8000_0001, 32'd1, mk(32'h2, 6'b111011, 6'b100010, 1'b0));
    send(4'd6, 2'd2, 32'h8000_0001, 32'd0, mk(32'h8000_0001, 6'b000000, 6'b0, 1'b0));
    send(4'd6, 2'd2, 32'h4000_0000, 32'd1, mk(32'h8000_0000, 6'b111011, 6'b110001, 1'b0));
    send(4'd2, 2'd1, 32'h1234, 32'h0000, mk(32'h1234, 6'b001000, 6'b001000, 1'b0));
    send(4'd2, 2'd1, 32'h1234, 32'h0080, mk(32'h7, 6'b001000, 6'b000000, 1'b0));
    send(4'd0, 2'd1, 32'hABCD_FFFF, 32'h1, mk(32'h0, 6'b111111, 6'b001111, 1'b0));
    send(4'd1, 2'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 6'b111011, 6'b010001, 1'b0));
    send(4'd4, 2'd0, 32'h1234_560F, 32'hF0, mk(32'hFF, 6'b111011, 6'b010001, 1'b0));
    send(4'd3, 2'd1, 32'h00FF, 32'h0, mk(32'hFF00, 6'b000000, 6'b0, 1'b0));
    send(4'd5, 2'd0, 32'h0, 32'h1234, mk(32'h34, 6'b000000, 6'b0, 1'b0));
    send(4'd7, 2'd0, 32'h81, 32'd4, mk(32'hF8, 6'b011011, 6'b010000, 1'b0));
    send(4'd6, 2'd0, 32'h01, 32'd8, mk(32'h0, 6'b011011, 6'b001001, 1'b0));
    send(4'd7, 2'd1, 32'h8000, 32'd20, mk(32'hFFFF, 6'b011011, 6'b010011, 1'b0));
    send(4'd0, 2'd3, 32'h1, 32'h1, mk(32'h0, 6'b0, 6'b0, 1'b1));
    send(4'd2, 2'd0, 32'h1, 32'h1, mk(32'h0, 6'b0, 6'b0, 1'b1));
    send(4'd11, 2'd2, 32'h1, 32'h1, mk(32'h0, 6'b0, 6'b0, 1'b1));
`ifdef ALU_PIPE_SUB_EN
    send(4'd8, 2'd0, 32'h00, 32'h01, mk(32'hFF, 6'b111111, 6'b011111, 1'b0));
    send(4'd9, 2'd2, 32'h5, 32'h5, mk(32'h5, 6'b111111, 6'b001001, 1'b0));
`else
    send(4'd8, 2'd0, 32'h00, 32'h01, mk(32'h0, 6'b0, 6'b0, 1'b1));
    send(4'd9, 2'd2, 32'h5, 32'h5, mk(32'h0, 6'b0, 6'b0, 1'b1));
`endif
    drain();

    // burst of four with three cycles of back-pressure
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(4'd5, 2'd2, 32'h0, 32'(i * 17), mk(32'(i * 17), 6'b0, 6'b0, 1'b0));
      end
      begin
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk); #1;
        chk("stall_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // flush with both stages occupied
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd5, 2'd2, 32'h0, 32'hAAAA, mk(32'hAAAA, 6'b0, 6'b0, 1'b0));
    send(4'd5, 2'd2, 32'h0, 32'hBBBB, mk(32'hBBBB, 6'b0, 6'b0, 1'b0));
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("flush_out_valid", out_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    send(4'd5, 2'd2, 32'h0, 32'hCCCC, mk(32'hCCCC, 6'b0, 6'b0, 1'b0));
    drain();

    // reset mid-stream with both stages occupied
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd5, 2'd2, 32'h0, 32'hDDDD, mk(32'hDDDD, 6'b0, 6'b0, 1'b0));
    send(4'd5, 2'd2, 32'h0, 32'hEEEE, mk(32'hEEEE, 6'b0, 6'b0, 1'b0));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    send(4'd0, 2'd0, 32'h1, 32'h1, mk(32'h2, 6'b111111, 6'b000000, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
